// File: rtl/mul_div_alu_if.sv
// Operand/result bundle between the pipeline and the ALU plus mul/div unit.
// No latency of its own; it only groups wires.
// No backpressure here; Stall and Busy travel on it from the ALU.
//
// Ports (master = pipeline/controller, slave = ALU):
//   DataIn1/DataIn2 operands, Shamt shift amount, AluCtrl op select, Start issue strobe;
//   AluResult/Zero/Overflow combinational results, Busy/Done mul/div status, Stall hazard,
//   Hi/Lo architectural registers.
interface mul_div_alu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic [WIDTH-1:0]   DataIn1;
    logic [WIDTH-1:0]   DataIn2;
    logic [SHAMT_W-1:0] Shamt;
    logic [4:0]         AluCtrl;
    logic               Start;
    logic [WIDTH-1:0]   AluResult;
    logic               Zero;
    logic               Overflow;
    logic               Busy;
    logic               Done;
    logic               Stall;
    logic [WIDTH-1:0]   Hi;
    logic [WIDTH-1:0]   Lo;

    modport master (
        output DataIn1, DataIn2, Shamt, AluCtrl, Start,
        input  AluResult, Zero, Overflow, Busy, Done, Stall, Hi, Lo
    );

    modport slave (
        input  DataIn1, DataIn2, Shamt, AluCtrl, Start,
        output AluResult, Zero, Overflow, Busy, Done, Stall, Hi, Lo
    );
endinterface

// File: rtl/mul_div_alu.sv
// Single-cycle ALU plus iterative radix-2 multiply/divide writing HI/LO.
// ALU ops have zero latency; mul/div keep Busy high for WIDTH+1 cycles and pulse Done at the end.
// Start while Busy is dropped without queueing; Stall flags mul/div/HI/LO ops issued while Busy.
//
// Ports: clk, rst_n (async active-low) as scalars; everything else travels on
// mul_div_alu_if.slave (operands, Shamt, AluCtrl, Start in; AluResult, Zero,
// Overflow, Busy, Done, Stall, Hi, Lo out).
module mul_div_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_div_alu_if.slave bus
);
    localparam logic [4:0] OP_ADDU = 5'd0,  OP_SUBU = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4,  OP_SUB  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8,  OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_XOR  = 5'd11;
    localparam logic [4:0] OP_NOR  = 5'd12, OP_MULT = 5'd13, OP_MULTU = 5'd14, OP_DIV = 5'd15;
    localparam logic [4:0] OP_DIVU = 5'd16, OP_MFHI = 5'd17, OP_MFLO = 5'd18, OP_MTHI = 5'd19;
    localparam logic [4:0] OP_MTLO = 5'd20;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_FIX = 2'd2;

    logic [1:0]         r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_busy, r_done;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_is_div;   // divide vs multiply for the op in flight
    logic               r_neg_q;    // negate product / quotient in FIX
    logic               r_neg_r;    // negate remainder in FIX
    logic               r_div0;     // divisor was zero
    logic [WIDTH-1:0]   r_dvd;      // raw dividend, returned in HI on divide-by-zero
    logic [WIDTH-1:0]   r_opnd;     // |multiplicand| or |divisor|
    logic [WIDTH:0]     r_acc_hi;   // partial product high half / partial remainder
    logic [WIDTH-1:0]   r_acc_lo;   // multiplier shifting out / quotient shifting in

    logic [WIDTH-1:0]   w_a, w_b, w_sum, w_diff, w_res;
    logic               w_slt, w_is_md, w_signed, w_accept;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot, w_rem;
    logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_trial;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    assign w_a    = bus.DataIn1;
    assign w_b    = bus.DataIn2;
    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;
    assign w_slt  = $signed(w_a) < $signed(w_b);

    always_comb begin
        w_res = '0;
        case (bus.AluCtrl)
            OP_ADDU, OP_ADD: w_res = w_sum;
            OP_SUBU, OP_SUB: w_res = w_diff;
            OP_AND:          w_res = w_a & w_b;
            OP_OR:           w_res = w_a | w_b;
            OP_SLL:          w_res = w_b << bus.Shamt;
            OP_SRL:          w_res = w_b >> bus.Shamt;
            OP_SRA:          w_res = $unsigned($signed(w_b) >>> bus.Shamt);
            OP_SLT:          w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLTU:         w_res = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            OP_XOR:          w_res = w_a ^ w_b;
            OP_NOR:          w_res = ~(w_a | w_b);
            OP_MFHI:         w_res = r_hi;
            OP_MFLO:         w_res = r_lo;
            default:         w_res = '0;
        endcase
    end

    assign bus.AluResult = w_res;
    // SUBU doubles as the BNE compare, so its flag is inverted.
    assign bus.Zero      = (bus.AluCtrl == OP_SUBU) ? (w_a != w_b) : (w_a == w_b);
    assign bus.Overflow  = ((bus.AluCtrl == OP_ADD) && (w_a[WIDTH-1] == w_b[WIDTH-1])
                                                    && (w_sum[WIDTH-1] != w_a[WIDTH-1]))
                        || ((bus.AluCtrl == OP_SUB) && (w_a[WIDTH-1] != w_b[WIDTH-1])
                                                    && (w_diff[WIDTH-1] != w_a[WIDTH-1]));
    assign bus.Stall     = r_busy && (bus.AluCtrl >= OP_MULT) && (bus.AluCtrl <= OP_MTLO);
    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;

    // Issue-side decode: signed ops work on magnitudes and fix the sign afterwards.
    assign w_accept = bus.Start && !r_busy;
    assign w_is_md  = (bus.AluCtrl >= OP_MULT) && (bus.AluCtrl <= OP_DIVU);
    assign w_signed = (bus.AluCtrl == OP_MULT) || (bus.AluCtrl == OP_DIV);
    assign w_abs_a  = (w_signed && w_a[WIDTH-1]) ? (~w_a + WIDTH'(1)) : w_a;
    assign w_abs_b  = (w_signed && w_b[WIDTH-1]) ? (~w_b + WIDTH'(1)) : w_b;

    // One shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
    assign w_mul_sum   = r_acc_lo[0] ? (r_acc_hi + {1'b0, r_opnd}) : r_acc_hi;
    // One restoring-division step: bring in the next dividend bit and try a subtract.
    assign w_div_shift = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};

    assign w_prod      = {r_acc_hi[WIDTH-1:0], r_acc_lo};
    assign w_prod_fix  = r_neg_q ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
    assign w_quot      = r_neg_q ? (~r_acc_lo + WIDTH'(1)) : r_acc_lo;
    assign w_rem       = r_neg_r ? (~r_acc_hi[WIDTH-1:0] + WIDTH'(1)) : r_acc_hi[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_dvd    <= '0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.AluCtrl == OP_MTHI) begin
                            r_hi <= w_a;
                        end else if (bus.AluCtrl == OP_MTLO) begin
                            r_lo <= w_a;
                        end else if (w_is_md) begin
                            r_is_div <= (bus.AluCtrl == OP_DIV) || (bus.AluCtrl == OP_DIVU);
                            r_neg_q  <= w_signed && (w_a[WIDTH-1] ^ w_b[WIDTH-1]);
                            r_neg_r  <= w_signed && w_a[WIDTH-1];
                            r_div0   <= ((bus.AluCtrl == OP_DIV) || (bus.AluCtrl == OP_DIVU))
                                        && (w_b == '0);
                            r_dvd    <= w_a;
                            // Multiply: A is the multiplicand, B shifts out of acc_lo.
                            // Divide: B is the divisor, A shifts out of acc_lo.
                            r_opnd   <= w_is_md && (bus.AluCtrl >= OP_DIV) ? w_abs_b : w_abs_a;
                            r_acc_lo <= w_is_md && (bus.AluCtrl >= OP_DIV) ? w_abs_a : w_abs_b;
                            r_acc_hi <= '0;
                            r_cnt    <= SHAMT_W'(WIDTH-1);
                            r_busy   <= 1'b1;
                            r_state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (r_is_div) begin
                        r_acc_hi <= w_div_ok ? w_div_trial : w_div_shift;
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ok};
                    end else begin
                        r_acc_hi <= {1'b0, w_mul_sum[WIDTH:1]};
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                    if (r_cnt == '0) r_state <= ST_FIX;
                    else             r_cnt   <= r_cnt - SHAMT_W'(1);
                end
                ST_FIX: begin
                    if (r_is_div && r_div0) begin
                        r_hi <= r_dvd;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_alu.sv
module tb_mul_div_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_div_alu_if #(.WIDTH(W), .SHAMT_W(5)) bus ();

    mul_div_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] md_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            5'd13: return 64'(sa * sb);
            5'd14: return ua * ub;
            5'd15: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic comb_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                              input logic [4:0] op, input logic [31:0] hi, input logic [31:0] lo,
                              output logic [31:0] res, output logic z, output logic ov);
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 32'd0;
        ov  = 1'b0;
        case (op)
            5'd0, 5'd4: res = a + b;
            5'd1, 5'd5: res = a - b;
            5'd2:  res = a & b;
            5'd3:  res = a | b;
            5'd6:  res = b << sh;
            5'd7:  res = b >> sh;
            5'd8:  res = $unsigned($signed(b) >>> sh);
            5'd9:  res = (sa < sb) ? 32'd1 : 32'd0;
            5'd10: res = (a < b) ? 32'd1 : 32'd0;
            5'd11: res = a ^ b;
            5'd12: res = ~(a | b);
            5'd17: res = hi;
            5'd18: res = lo;
            default: res = 32'd0;
        endcase
        if (op == 5'd4) begin
            t  = sa + sb;
            ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        end else if (op == 5'd5) begin
            t  = sa - sb;
            ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        end
        z = (op == 5'd1) ? (a != b) : (a == b);
    endtask

    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_res = 64'd0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_hi <= 32'd0; m_lo <= 32'd0;
            m_left <= 0;    m_res  <= 64'd0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.Start) begin
                if (bus.AluCtrl == 5'd19)      m_hi <= bus.DataIn1;
                else if (bus.AluCtrl == 5'd20) m_lo <= bus.DataIn1;
                else if (bus.AluCtrl >= 5'd13 && bus.AluCtrl <= 5'd16) begin
                    m_busy <= 1'b1;
                    m_left <= W;
                    m_res  <= md_model(bus.AluCtrl, bus.DataIn1, bus.DataIn2);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] e_res;
        logic        e_z, e_ov;
        comb_model(bus.DataIn1, bus.DataIn2, bus.Shamt, bus.AluCtrl, m_hi, m_lo, e_res, e_z, e_ov);
        chk("cmp AluResult", bus.AluResult, e_res);
        chk("cmp Zero", bus.Zero, e_z);
        chk("cmp Overflow", bus.Overflow, e_ov);
        chk("cmp Busy", bus.Busy, m_busy);
        chk("cmp Done", bus.Done, m_done);
        chk("cmp Hi", bus.Hi, m_hi);
        chk("cmp Lo", bus.Lo, m_lo);
        chk("cmp Stall", bus.Stall, m_busy && bus.AluCtrl >= 5'd13 && bus.AluCtrl <= 5'd20);
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ov, z;
    } vec_t;

    vec_t vecs[18];

    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int restart_at,
                          input string nm);
        int cyc, busy_cnt;
        bit seen;
        @(posedge clk); #1;
        bus.DataIn1 = a; bus.DataIn2 = b; bus.AluCtrl = op; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.AluCtrl = 5'd18;
        bus.DataIn1 = ~a; bus.DataIn2 = 32'h5A5A5A5A;
        cyc = 0; busy_cnt = 0; seen = 0;
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({nm, " stall"}, bus.Stall, 1'b1);
            if (bus.Busy) busy_cnt++;
            if (bus.Done) seen = 1;
            if (!seen && cyc == restart_at) begin
                #1; bus.Start = 1'b1; bus.AluCtrl = 5'd14; bus.DataIn1 = 32'd2; bus.DataIn2 = 32'd3;
            end else if (!seen && restart_at > 0 && cyc == restart_at + 1) begin
                #1; bus.Start = 1'b0; bus.AluCtrl = 5'd18;
            end
        end
        chk({nm, " done seen"}, seen, 1'b1);
        chk({nm, " busy cycles"}, busy_cnt, W + 1);
        chk({nm, " hi"}, bus.Hi, eh);
        chk({nm, " lo"}, bus.Lo, el);
        @(negedge clk);
        chk({nm, " done clears"}, bus.Done, 1'b0);
    endtask

    initial begin
        int done_cnt;
        vecs[0]  = '{5'd4,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0};
        vecs[1]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0};
        vecs[2]  = '{5'd8,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0};
        vecs[3]  = '{5'd9,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0};
        vecs[4]  = '{5'd10, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[5]  = '{5'd5,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[6]  = '{5'd1,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[7]  = '{5'd1,  32'h00000005, 32'h00000003, 5'd0,  32'h00000002, 1'b0, 1'b1};
        vecs[8]  = '{5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
        vecs[9]  = '{5'd3,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[10] = '{5'd11, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0, 1'b0};
        vecs[11] = '{5'd12, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0, 1'b0};
        vecs[12] = '{5'd6,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0};
        vecs[13] = '{5'd7,  32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};
        vecs[14] = '{5'd4,  32'h12345678, 32'h12345678, 5'd0,  32'h2468ACF0, 1'b0, 1'b1};
        vecs[15] = '{5'd25, 32'h00000001, 32'h00000002, 5'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[16] = '{5'd13, 32'h00000003, 32'h00000003, 5'd0,  32'h00000000, 1'b0, 1'b1};
        vecs[17] = '{5'd5,  32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b0};

        bus.DataIn1 = '0; bus.DataIn2 = '0; bus.Shamt = '0; bus.AluCtrl = '0; bus.Start = 1'b0;

        @(posedge clk); #1;
        chk("reset busy", bus.Busy, 1'b0);
        chk("reset done", bus.Done, 1'b0);
        chk("reset hi", bus.Hi, 32'd0);
        chk("reset lo", bus.Lo, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            bus.AluCtrl = vecs[i].op; bus.DataIn1 = vecs[i].a;
            bus.DataIn2 = vecs[i].b;  bus.Shamt   = vecs[i].sh;
            #1;
            chk($sformatf("vec%0d result", i), bus.AluResult, vecs[i].res);
            chk($sformatf("vec%0d overflow", i), bus.Overflow, vecs[i].ov);
            chk($sformatf("vec%0d zero", i), bus.Zero, vecs[i].z);
        end
        bus.Shamt = '0;

        run_md(5'd13, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, "mult -3x7");
        #1; bus.AluCtrl = 5'd18; #1;
        chk("mflo idle", bus.AluResult, 32'hFFFFFFEB);
        chk("mflo no stall", bus.Stall, 1'b0);
        bus.AluCtrl = 5'd17; #1;
        chk("mfhi idle", bus.AluResult, 32'hFFFFFFFF);

        run_md(5'd15, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div -7/2");
        run_md(5'd16, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0, "divu 5/0");
        run_md(5'd15, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, "div min/-1");
        run_md(5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 10, "multu max");

        @(posedge clk); #1;
        bus.AluCtrl = 5'd19; bus.DataIn1 = 32'h1234; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.AluCtrl = 5'd0;
        chk("mthi hi", bus.Hi, 32'h1234);
        chk("mthi busy", bus.Busy, 1'b0);

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        bus.AluCtrl = 5'd15; bus.DataIn1 = 32'd100; bus.DataIn2 = 32'd7; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.AluCtrl = 5'd0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst busy", bus.Busy, 1'b0);
        chk("async rst done", bus.Done, 1'b0);
        chk("async rst hi", bus.Hi, 32'd0);
        chk("async rst lo", bus.Lo, 32'd0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.Done) done_cnt++;
        end
        #3 rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done) done_cnt++;
        end
        chk("no done after reset", done_cnt, 0);

        run_md(5'd13, 32'd2, 32'd3, 32'd0, 32'd6, 0, "mult 2x3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mul_div_alu.md
Name: mul_div_alu

Overview:
- Parametrised successor to the single-cycle datapath ALU in the MIPS core.
- Keeps a combinational single-cycle op set and adds the missing ops: SRA, SLTU, XOR and NOR.
- Adds signed-overflow detection.
- Adds an iterative multi-cycle multiply/divide unit with architectural HI/LO registers, a Start/Busy/Done handshake and a Stall output for the pipeline/controller.

Parameters:
- WIDTH, 32, datapath width in bits; must be at least 4.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- DataIn1  input  WIDTH  operand A (rs).
- DataIn2  input  WIDTH  operand B (rt).
- Shamt  input  SHAMT_W  shift amount.
- AluCtrl  input  5  operation select (encoding below).
- Start  input  1  issue strobe for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- AluResult  output  WIDTH  combinational result.
- Zero  output  1  combinational branch-compare flag.
- Overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- Busy  output  1  registered; mul/div in progress.
- Done  output  1  registered; one-cycle pulse on the cycle HI/LO take a mul/div result.
- Stall  output  1  combinational; Busy & (AluCtrl is MULT..MTLO).
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- AluCtrl encoding: 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 ADD, 5 SUB, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 XOR, 12 NOR, 13 MULT, 14 MULTU, 15 DIV, 16 DIVU, 17 MFHI, 18 MFLO, 19 MTHI, 20 MTLO.
- Codes 21-31: AluResult=0, no state change.
- Single-cycle ops (0-12) are purely combinational with zero latency.
- All arithmetic is modulo 2^WIDTH.
- Shifts operate on DataIn2 by Shamt. SRA replicates DataIn2[WIDTH-1].
- SLT is signed and SLTU unsigned; both give 1/0 zero-extended.
- Zero = (DataIn1 == DataIn2) for every op except SUBU, which gives Zero = (DataIn1 != DataIn2) and is used for BNE.
- Overflow = 1 for ADD when the operand signs are equal and the result sign differs; for SUB when the operand signs differ and the result sign differs from DataIn1.
- MFHI/MFLO: AluResult = Hi/Lo. While Busy, the old value is driven and Stall=1.
- MULT..DIVU: AluResult=0.
- Issue rule: Start is accepted only when Busy=0 at the rising edge. Start while Busy=1 is ignored: no queueing, no state change.
- MTHI/MTLO on an accepted Start: Hi (Lo) <= DataIn1 at that edge; Busy stays 0.
- FSM states: IDLE, CALC, FIX.
- IDLE -> CALC on accepted Start with AluCtrl 13-16. At this edge the unit latches the operands and op, stores absolute values for signed ops, loads counter=WIDTH-1, and sets Busy=1.
- CALC: one radix-2 step per cycle for WIDTH cycles; shift-add for multiply, restoring division for divide. Leaves to FIX when counter=0.
- FIX: one cycle; applies sign correction. At the FIX->IDLE edge Hi/Lo are written, Busy<=0 and Done<=1; Done clears on the next edge.
- Latency: Busy is high for exactly WIDTH+1 cycles; Hi/Lo are valid in the cycle Done=1.
- Multiply: {Hi,Lo} = 2*WIDTH-bit product. For signed ops the product is negated when the operand signs differ.
- Divide: Lo = quotient truncated toward zero, Hi = remainder with the dividend's sign.
- Divide by zero (DIV or DIVU): Hi = dividend, Lo = all ones; full latency still applies.
- DIV of most-negative by -1: Lo = most-negative, Hi = 0.
- The operation uses operands latched at issue; later DataIn changes have no effect.
- Reset (asynchronous, any time including mid-CALC/FIX): state=IDLE, Busy=0, Done=0, Hi=0, Lo=0, all internal accumulators/counters=0. The in-flight result is discarded.
- Combinational outputs follow their inputs during reset.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> AluResult=0x80000000, Overflow=1. ADDU with the same operands -> Overflow=0.
- SRA DataIn2=0x80000000, Shamt=4 -> 0xF8000000. SLT 0xFFFFFFFF,1 -> 1. SLTU with the same operands -> 0.
- MULT -3 × 7 with Start pulse -> Busy high 33 cycles, Done 1-cycle pulse, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. MFLO during Busy -> Stall=1.
- DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 5 / 0 -> Hi=5, Lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, then a second Start 10 cycles in -> second Start ignored; Hi=0xFFFFFFFE, Lo=0x00000001. MTHI 0x1234 when idle -> Hi=0x1234 the next cycle.
- Assert rst_n=0 asynchronously mid-CALC of a DIV -> Busy, Done, Hi and Lo go to 0 immediately; Done never pulses. A new MULT 2×3 issued after release -> Lo=6.
